// File: rtl/colour_cls_pkg.sv
// Shared definitions for the YCbCr colour classifier: threshold field
// encodings and the reset value of each field.
package colour_cls_pkg;

  localparam int NUM_FIELDS = 6;

  localparam logic [2:0] FLD_YMIN  = 3'd0;
  localparam logic [2:0] FLD_YMAX  = 3'd1;
  localparam logic [2:0] FLD_CBMIN = 3'd2;
  localparam logic [2:0] FLD_CBMAX = 3'd3;
  localparam logic [2:0] FLD_CRMIN = 3'd4;
  localparam logic [2:0] FLD_CRMAX = 3'd5;

  // Odd field codes are upper bounds and reset fully open; lower bounds reset to 0.
  function automatic logic [63:0] field_default(input int data_w, input int fld);
    return (fld % 2 == 1) ? ((64'd1 << data_w) - 64'd1) : 64'd0;
  endfunction

endpackage

// File: rtl/range_cmp_strict.sv
// Registered strict window compare: hit is lo < x < hi, one cycle later.
module range_cmp_strict #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  output logic              hit
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit <= 1'b0;
    else     hit <= (x > lo) && (x < hi);
  end

endmodule

// File: rtl/ycbcr_color_classifier.sv
// Programmable YCbCr window classifier: 2-stage mask pipeline, class and
// table changes taken only at frame start, saturating per-frame match count.
module ycbcr_color_classifier
  import colour_cls_pkg::*;
#(
  parameter  int DATA_W      = 8,
  parameter  int NUM_CLASSES = 4,
  parameter  int CNT_W       = 20,
  localparam int CLASS_W     = $clog2(NUM_CLASSES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               per_frame_vsync,
  input  logic               per_frame_href,
  input  logic               per_frame_clken,
  input  logic [DATA_W-1:0]  per_img_Y,
  input  logic [DATA_W-1:0]  per_img_Cb,
  input  logic [DATA_W-1:0]  per_img_Cr,
  input  logic               key_color,
  input  logic               cfg_we,
  input  logic [CLASS_W-1:0] cfg_class,
  input  logic [2:0]         cfg_field,
  input  logic [DATA_W-1:0]  cfg_data,
  output logic               post_frame_vsync,
  output logic               post_frame_href,
  output logic               post_frame_clken,
  output logic               post_img_Bit,
  output logic [CLASS_W-1:0] post_class,
  output logic [CNT_W-1:0]   frame_pix_cnt,
  output logic               frame_cnt_valid
);

  typedef logic [NUM_FIELDS-1:0][DATA_W-1:0]  entry_t;
  typedef entry_t [NUM_CLASSES-1:0]           table_t;

  function automatic table_t table_default();
    table_t t;
    for (int c = 0; c < NUM_CLASSES; c++)
      for (int f = 0; f < NUM_FIELDS; f++)
        t[c][f] = DATA_W'(field_default(DATA_W, f));
    return t;
  endfunction

  localparam table_t           TABLE_RST = table_default();
  localparam logic [CLASS_W:0] CLASS_LIM = (CLASS_W+1)'(NUM_CLASSES);
  localparam logic [2:0]       FIELD_LIM = 3'(NUM_FIELDS);
  localparam logic [CLASS_W-1:0] CLASS_LAST = CLASS_W'(NUM_CLASSES - 1);

  logic               vsync_q, key_q;
  logic               fs, key_rise, cfg_ok;
  logic [2:0]         sync_d1, sync_d2;
  logic [CLASS_W-1:0] pending_class, pending_nxt, active_class;
  table_t             shadow, shadow_nxt, active_tbl;
  entry_t             cur_win;
  logic               hit_y, hit_cb, hit_cr, s2_bit;
  logic [CNT_W-1:0]   cnt;

  assign fs       = per_frame_vsync & ~vsync_q;
  assign key_rise = key_color & ~key_q;
  assign cfg_ok   = cfg_we && ({1'b0, cfg_class} < CLASS_LIM) && (cfg_field < FIELD_LIM);

  always_comb begin
    pending_nxt = pending_class;
    if (key_rise)
      pending_nxt = (pending_class == CLASS_LAST) ? '0 : pending_class + CLASS_W'(1);
  end

  // The next-state shadow is what gets copied at fs, so a same-cycle write lands in the active copy.
  always_comb begin
    shadow_nxt = shadow;
    if (cfg_ok) shadow_nxt[cfg_class][cfg_field] = cfg_data;
  end

  assign cur_win = active_tbl[active_class];

  range_cmp_strict #(.DATA_W(DATA_W)) u_cmp_y (
    .clk(clk), .rst(rst), .x(per_img_Y),
    .lo(cur_win[FLD_YMIN]), .hi(cur_win[FLD_YMAX]), .hit(hit_y)
  );

  range_cmp_strict #(.DATA_W(DATA_W)) u_cmp_cb (
    .clk(clk), .rst(rst), .x(per_img_Cb),
    .lo(cur_win[FLD_CBMIN]), .hi(cur_win[FLD_CBMAX]), .hit(hit_cb)
  );

  range_cmp_strict #(.DATA_W(DATA_W)) u_cmp_cr (
    .clk(clk), .rst(rst), .x(per_img_Cr),
    .lo(cur_win[FLD_CRMIN]), .hi(cur_win[FLD_CRMAX]), .hit(hit_cr)
  );

  assign s2_bit = hit_y & hit_cb & hit_cr & sync_d1[1] & sync_d1[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q      <= 1'b0;
      key_q        <= 1'b0;
      sync_d1      <= '0;
      sync_d2      <= '0;
      post_img_Bit <= 1'b0;
    end else begin
      vsync_q      <= per_frame_vsync;
      key_q        <= key_color;
      sync_d1      <= {per_frame_vsync, per_frame_href, per_frame_clken};
      sync_d2      <= sync_d1;
      post_img_Bit <= s2_bit;
    end
  end

  assign post_frame_vsync = sync_d2[2];
  assign post_frame_href  = sync_d2[1];
  assign post_frame_clken = sync_d2[0];
  assign post_class       = active_class;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_class <= '0;
      active_class  <= '0;
      shadow        <= TABLE_RST;
      active_tbl    <= TABLE_RST;
    end else begin
      pending_class <= pending_nxt;
      shadow        <= shadow_nxt;
      if (fs) begin
        active_class <= pending_nxt;
        active_tbl   <= shadow_nxt;
      end
    end
  end

  // A match landing in the fs cycle is dropped: the clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt             <= '0;
      frame_pix_cnt   <= '0;
      frame_cnt_valid <= 1'b0;
    end else begin
      frame_cnt_valid <= fs;
      if (fs) begin
        frame_pix_cnt <= cnt;
        cnt           <= '0;
      end else if (s2_bit && !(&cnt)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ycbcr_color_classifier.sv
// Bench for ycbcr_color_classifier: two instances (default and 3-class/4-bit count)
// driven in parallel and compared every cycle against a frame-level reference model.
module tb_ycbcr_color_classifier;

  logic       clk = 1'b0;
  logic       rst;
  logic       vs, hs, ck, key, we;
  logic [7:0] y, cb, cr, wd;
  logic [1:0] wc;
  logic [2:0] wf;

  logic [1:0]  o_vs, o_hs, o_ck, o_bit, o_val;
  logic [1:0]  o_cls_a, o_cls_b;
  logic [19:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ycbcr_color_classifier dut_a (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vs), .per_frame_href(hs), .per_frame_clken(ck),
    .per_img_Y(y), .per_img_Cb(cb), .per_img_Cr(cr),
    .key_color(key), .cfg_we(we), .cfg_class(wc), .cfg_field(wf), .cfg_data(wd),
    .post_frame_vsync(o_vs[0]), .post_frame_href(o_hs[0]), .post_frame_clken(o_ck[0]),
    .post_img_Bit(o_bit[0]), .post_class(o_cls_a),
    .frame_pix_cnt(cnt_a), .frame_cnt_valid(o_val[0])
  );

  ycbcr_color_classifier #(.NUM_CLASSES(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vs), .per_frame_href(hs), .per_frame_clken(ck),
    .per_img_Y(y), .per_img_Cb(cb), .per_img_Cr(cr),
    .key_color(key), .cfg_we(we), .cfg_class(wc), .cfg_field(wf), .cfg_data(wd),
    .post_frame_vsync(o_vs[1]), .post_frame_href(o_hs[1]), .post_frame_clken(o_ck[1]),
    .post_img_Bit(o_bit[1]), .post_class(o_cls_b),
    .frame_pix_cnt(cnt_b), .frame_cnt_valid(o_val[1])
  );

  // Reference model state, one copy per instance
  int ncls[2] = '{4, 3};
  int cmax[2] = '{(1 << 20) - 1, 15};
  int sh[2][4][6];
  int act[2][4][6];
  int pend[2], acls[2], cnt[2], fcnt[2];
  bit fval[2];
  bit prev_vs, prev_key;
  bit dl_vs, dl_hs, dl_ck;
  bit dl_bit[2];
  bit e_vs, e_hs, e_ck;
  bit e_bit[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 4; c++)
        for (int f = 0; f < 6; f++) begin
          sh[i][c][f]  = (f % 2 == 1) ? 255 : 0;
          act[i][c][f] = (f % 2 == 1) ? 255 : 0;
        end
      pend[i] = 0; acls[i] = 0; cnt[i] = 0; fcnt[i] = 0; fval[i] = 0;
      dl_bit[i] = 0; e_bit[i] = 0;
    end
    prev_vs = 0; prev_key = 0;
    dl_vs = 0; dl_hs = 0; dl_ck = 0;
    e_vs = 0; e_hs = 0; e_ck = 0;
  endtask

  function automatic bit in_win(int i);
    int c = acls[i];
    return (int'(y)  > act[i][c][0]) && (int'(y)  < act[i][c][1]) &&
           (int'(cb) > act[i][c][2]) && (int'(cb) < act[i][c][3]) &&
           (int'(cr) > act[i][c][4]) && (int'(cr) < act[i][c][5]);
  endfunction

  // One clock edge of the behaviour: inputs here are those sampled at the edge.
  task automatic model_edge();
    bit fs, kr;
    bit m[2];
    fs = vs && !prev_vs;
    kr = key && !prev_key;
    for (int i = 0; i < 2; i++) m[i] = ck && hs && in_win(i);
    for (int i = 0; i < 2; i++) begin
      if (kr) pend[i] = (pend[i] + 1) % ncls[i];
      if (we && int'(wc) < ncls[i] && int'(wf) < 6) sh[i][wc][wf] = int'(wd);
      if (fs) begin
        act[i]  = sh[i];
        acls[i] = pend[i];
        fcnt[i] = cnt[i];
        fval[i] = 1;
        cnt[i]  = 0;
      end else begin
        fval[i] = 0;
        if (dl_bit[i] && cnt[i] < cmax[i]) cnt[i]++;
      end
      e_bit[i]  = dl_bit[i];
      dl_bit[i] = m[i];
    end
    e_vs = dl_vs; e_hs = dl_hs; e_ck = dl_ck;
    dl_vs = vs; dl_hs = hs; dl_ck = ck;
    prev_vs = vs; prev_key = key;
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("vs%0d", i),  o_vs[i],  e_vs);
      chk($sformatf("hs%0d", i),  o_hs[i],  e_hs);
      chk($sformatf("ck%0d", i),  o_ck[i],  e_ck);
      chk($sformatf("bit%0d", i), o_bit[i], e_bit[i]);
      chk($sformatf("val%0d", i), o_val[i], fval[i]);
    end
    chk("cls0", o_cls_a, acls[0]);
    chk("cls1", o_cls_b, acls[1]);
    chk("cnt0", cnt_a,   fcnt[0]);
    chk("cnt1", cnt_b,   fcnt[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    vs = 0; hs = 0; ck = 0;
    repeat (n) tick();
  endtask

  task automatic pix(input int yy, input int cbv, input int crv);
    vs = 0; hs = 1; ck = 1;
    y = 8'(yy); cb = 8'(cbv); cr = 8'(crv);
    tick();
  endtask

  task automatic pix_chk(input string tag, input int yy, input int cbv, input int crv,
                         input bit exp);
    pix(yy, cbv, crv);
    hs = 0; ck = 0;
    tick();
    chk(tag, o_bit[0], exp);
  endtask

  task automatic wr(input int c, input int f, input int d);
    we = 1; wc = 2'(c); wf = 3'(f); wd = 8'(d);
    hs = 0; ck = 0;
    tick();
    we = 0;
  endtask

  task automatic key_edge();
    key = 1; tick();
    key = 0; tick();
  endtask

  task automatic frame_start(input int exp_a, input int exp_b);
    idle(2);
    vs = 1;
    tick();
    if (exp_a >= 0) begin
      chk("fcnt_a", cnt_a, exp_a);
      chk("fval_a", o_val[0], 1);
    end
    if (exp_b >= 0) chk("fcnt_b", cnt_b, exp_b);
    tick();
    vs = 0;
    tick();
  endtask

  initial begin
    rst = 1; vs = 0; hs = 0; ck = 0; key = 0; we = 0;
    y = 0; cb = 0; cr = 0; wc = 0; wf = 0; wd = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 0;

    // Default window, 100 mid-grey pixels; small instance saturates at 15
    frame_start(0, 0);
    for (int k = 0; k < 100; k++) pix(128, 128, 128);
    frame_start(100, 15);

    // Strict boundaries on class 0
    wr(0, 0, 20);
    wr(0, 1, 206);
    wr(0, 2, 145);
    frame_start(-1, -1);
    pix_chk("y20",    20,  146, 128, 0);
    pix_chk("y21",    21,  146, 128, 1);
    pix_chk("y206",   206, 146, 128, 0);
    pix_chk("cb145",  21,  145, 128, 0);

    // Class advance waits for fs, then wraps
    repeat (3) key_edge();
    chk("cls_hold", o_cls_a, 0);
    frame_start(-1, -1);
    chk("cls_3", o_cls_a, 3);
    chk("cls_b0", o_cls_b, 0);
    key_edge();
    frame_start(-1, -1);
    chk("cls_wrap", o_cls_a, 0);
    chk("cls_b1", o_cls_b, 1);

    // Shadow write deferred to fs; write in fs cycle takes effect immediately
    wr(0, 1, 50);
    pix_chk("ymax_old", 100, 200, 128, 1);
    frame_start(-1, -1);
    pix_chk("ymax_100", 100, 200, 128, 0);
    pix_chk("ymax_40",  40,  200, 128, 1);
    idle(2);
    vs = 1; we = 1; wc = 0; wf = 1; wd = 30;
    tick();
    we = 0;
    tick();
    vs = 0;
    tick();
    pix_chk("fswr_40", 40, 200, 128, 0);
    pix_chk("fswr_25", 25, 200, 128, 1);

    // Invalid field codes, and class 3 which only the 3-class instance rejects
    wr(0, 6, 5);
    wr(0, 7, 5);
    wr(3, 0, 200);
    frame_start(-1, -1);
    pix_chk("inv_25", 25, 200, 128, 1);

    // Reset mid-frame
    for (int k = 0; k < 6; k++) pix(25, 200, 128);
    rst = 1;
    #1;
    model_reset();
    check_all();
    chk("rst_bit", o_bit[0], 0);
    @(negedge clk);
    rst = 0;
    frame_start(0, 0);
    for (int k = 0; k < 5; k++) pix(128, 128, 128);
    frame_start(5, 5);

    // Randomized frames with keys and writes landing anywhere, including fs cycles
    for (int fr = 0; fr < 25; fr++) begin
      for (int k = 0; k < 50; k++) begin
        vs  = (k < 3);
        hs  = (k >= 6 && k < 46) ? ($urandom_range(0, 7) != 0) : 1'b0;
        ck  = hs ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
        y   = 8'($urandom_range(0, 255));
        cb  = 8'($urandom_range(100, 255));
        cr  = 8'($urandom_range(0, 255));
        key = ($urandom_range(0, 5) == 0);
        we  = ($urandom_range(0, 9) == 0);
        wc  = 2'($urandom_range(0, 3));
        wf  = 3'($urandom_range(0, 7));
        wd  = 8'($urandom_range(0, 255));
        tick();
      end
    end
    we = 0; key = 0;
    frame_start(-1, -1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
